// File: rtl/rr_mux_arbiter_if.sv
// Stream bundle for rr_mux_arbiter: N request inputs muxed onto one registered output.
interface rr_mux_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
);
  localparam int unsigned L = $clog2(N);

  logic [N-1:0]         i_valid;
  logic [N-1:0][W-1:0]  i_data;
  logic [N-1:0]         i_last;
  logic [N-1:0]         i_ready;
  logic                 o_valid;
  logic [W-1:0]         o_data;
  logic                 o_last;
  logic [L-1:0]         o_src;
  logic                 o_ready;

  // Arbiter side.
  modport slave (
    input  i_valid, i_data, i_last, o_ready,
    output i_ready, o_valid, o_data, o_last, o_src
  );

  // Environment side: drives requests and downstream ready.
  modport master (
    output i_valid, i_data, i_last, o_ready,
    input  i_ready, o_valid, o_data, o_last, o_src
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Packet-aware round-robin N:1 stream mux. A grant locks onto one input until its
// last flit is accepted; output stage is a single register slice.
module rr_mux_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
) (
  input logic             clk,
  input logic             rst,
  rr_mux_arbiter_if.slave bus
);
  localparam int unsigned L = $clog2(N);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e         state_q;
  logic [L-1:0]   ptr_q;
  logic [L-1:0]   lock_q;
  logic           o_valid_q;
  logic [W-1:0]   o_data_q;
  logic           o_last_q;
  logic [L-1:0]   o_src_q;

  logic           load;
  logic           grant_vld;
  logic [L-1:0]   grant_idx;
  logic [L-1:0]   ptr_next;
  logic           xfer;
  logic [N-1:0]   ready;
  int unsigned    idx;

  assign load = !o_valid_q || bus.o_ready;

  // Locked state grants the owner even while it is idle, so no other input sneaks in.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (state_q == StLocked) begin
      grant_vld = 1'b1;
      grant_idx = lock_q;
    end else begin
      for (int unsigned off = 0; off < N; off++) begin
        idx = 32'(ptr_q) + off;
        if (idx >= N) idx = idx - N;
        if (!grant_vld && bus.i_valid[L'(idx)]) begin
          grant_vld = 1'b1;
          grant_idx = L'(idx);
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    if (!rst && load && grant_vld) ready[grant_idx] = 1'b1;
  end

  assign xfer     = |(ready & bus.i_valid);
  assign ptr_next = (grant_idx == L'(N - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      lock_q    <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      o_src_q   <= '0;
    end else if (xfer) begin
      o_valid_q <= 1'b1;
      o_data_q  <= bus.i_data[grant_idx];
      o_last_q  <= bus.i_last[grant_idx];
      o_src_q   <= grant_idx;
      if (bus.i_last[grant_idx]) begin
        state_q <= StIdle;
        ptr_q   <= ptr_next;
      end else begin
        state_q <= StLocked;
        lock_q  <= grant_idx;
      end
    end else if (bus.o_ready) begin
      o_valid_q <= 1'b0;
    end
  end

  assign bus.i_ready = ready;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_last  = o_last_q;
  assign bus.o_src   = o_src_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter at N=3, W=32 with hand-computed expectations.
module tb_rr_mux_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rr_mux_arbiter_if #(.N(3), .W(32)) bus ();

  rr_mux_arbiter #(.N(3), .W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [31:0] d2, input logic ordy);
    bus.i_valid   = v;
    bus.i_last    = l;
    bus.i_data[0] = d0;
    bus.i_data[1] = d1;
    bus.i_data[2] = d2;
    bus.o_ready   = ordy;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    drive(3'b000, 3'b000, 0, 0, 0, 1'b1);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(3'b111, 3'b111, 32'h1, 32'h2, 32'h3, 1'b1);
    #1;
    checks++;
    if (bus.i_ready !== 3'b000) begin
      errors++; $display("FAIL reset_ready_pre got=%b exp=000", bus.i_ready);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 32'h0 || bus.o_last !== 1'b0 ||
        bus.o_src !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h l=%b s=%0d exp v=0 d=0 l=0 s=0",
               bus.o_valid, bus.o_data, bus.o_last, bus.o_src);
    end
    checks++;
    if (bus.i_ready !== 3'b000) begin
      errors++; $display("FAIL reset_ready_held got=%b exp=000", bus.i_ready);
    end
    rst = 1'b0;
  endtask

  // Single-flit packets on all inputs: strict rotation 0,1,2,0.
  task automatic test_rr;
    logic [2:0]  exp_rdy [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [31:0] exp_d   [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA0};
    logic [1:0]  exp_s   [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    drive(3'b111, 3'b111, 32'hA0, 32'hA1, 32'hA2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.i_ready !== exp_rdy[i]) begin
        errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, bus.i_ready, exp_rdy[i]);
      end
      tick();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== exp_d[i] || bus.o_src !== exp_s[i]) begin
        errors++;
        $display("FAIL rr_out[%0d] got v=%b d=%h s=%0d exp v=1 d=%h s=%0d", i, bus.o_valid,
                 bus.o_data, bus.o_src, exp_d[i], exp_s[i]);
      end
    end
  endtask

  // Input 1 owns the output for a 3-flit packet while input 0 waits; ptr starts at 1.
  task automatic test_packet;
    logic [2:0]  exp_rdy [4] = '{3'b010, 3'b010, 3'b010, 3'b001};
    logic [31:0] in1_d   [4] = '{32'h11, 32'h22, 32'h33, 32'h0};
    logic [2:0]  in_v    [4] = '{3'b011, 3'b011, 3'b011, 3'b001};
    logic [2:0]  in_l    [4] = '{3'b001, 3'b001, 3'b011, 3'b001};
    logic [31:0] exp_d   [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [1:0]  exp_s   [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
    logic        exp_l   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(in_v[i], in_l[i], 32'h44, in1_d[i], 32'h0, 1'b1);
      #1;
      checks++;
      if (bus.i_ready !== exp_rdy[i]) begin
        errors++; $display("FAIL pkt_ready[%0d] got=%b exp=%b", i, bus.i_ready, exp_rdy[i]);
      end
      tick();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== exp_d[i] || bus.o_src !== exp_s[i] ||
          bus.o_last !== exp_l[i]) begin
        errors++;
        $display("FAIL pkt_out[%0d] got v=%b d=%h s=%0d l=%b exp v=1 d=%h s=%0d l=%b", i,
                 bus.o_valid, bus.o_data, bus.o_src, bus.o_last, exp_d[i], exp_s[i], exp_l[i]);
      end
    end
    drive(3'b000, 3'b000, 0, 0, 0, 1'b1);
    tick();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 32'h44) begin
      errors++;
      $display("FAIL pkt_drain got v=%b d=%h exp v=0 d=00000044", bus.o_valid, bus.o_data);
    end
  endtask

  // Downstream stall with A1 registered; A2 waits and follows on resume.
  task automatic test_stall;
    drive(3'b010, 3'b010, 0, 32'hA1, 0, 1'b1);
    tick();
    drive(3'b100, 3'b100, 0, 0, 32'hA2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.i_ready !== 3'b000) begin
        errors++; $display("FAIL stall_ready[%0d] got=%b exp=000", i, bus.i_ready);
      end
      tick();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== 32'hA1 || bus.o_src !== 2'd1) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b d=%h s=%0d exp v=1 d=000000a1 s=1", i,
                 bus.o_valid, bus.o_data, bus.o_src);
      end
    end
    bus.o_ready = 1'b1;
    #1;
    checks++;
    if (bus.i_ready !== 3'b100) begin
      errors++; $display("FAIL stall_resume_ready got=%b exp=100", bus.i_ready);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 32'hA2 || bus.o_src !== 2'd2) begin
      errors++;
      $display("FAIL stall_resume_out got v=%b d=%h s=%0d exp v=1 d=000000a2 s=2",
               bus.o_valid, bus.o_data, bus.o_src);
    end
    drive(3'b000, 3'b000, 0, 0, 0, 1'b1);
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL stall_no_dup got v=%b exp v=0", bus.o_valid);
    end
  endtask

  // Locked owner goes idle mid-packet: other inputs must not be granted.
  task automatic test_lock_gap;
    logic [2:0]  in_v    [4] = '{3'b011, 3'b010, 3'b011, 3'b010};
    logic [2:0]  in_l    [4] = '{3'b010, 3'b010, 3'b011, 3'b010};
    logic [31:0] in0_d   [4] = '{32'h66, 32'h0, 32'h67, 32'h0};
    logic [2:0]  exp_rdy [4] = '{3'b001, 3'b001, 3'b001, 3'b010};
    logic        exp_v   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_d   [4] = '{32'h66, 32'h66, 32'h67, 32'h99};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(in_v[i], in_l[i], in0_d[i], 32'h99, 0, 1'b1);
      #1;
      checks++;
      if (bus.i_ready !== exp_rdy[i]) begin
        errors++; $display("FAIL gap_ready[%0d] got=%b exp=%b", i, bus.i_ready, exp_rdy[i]);
      end
      tick();
      checks++;
      if (bus.o_valid !== exp_v[i] || bus.o_data !== exp_d[i]) begin
        errors++;
        $display("FAIL gap_out[%0d] got v=%b d=%h exp v=%b d=%h", i, bus.o_valid, bus.o_data,
                 exp_v[i], exp_d[i]);
      end
    end
  endtask

  // ptr=2 after a flit from input 1; inputs 0 and 2 then go 2 first, 0 next.
  task automatic test_wrap;
    logic [2:0]  exp_rdy [2] = '{3'b100, 3'b001};
    logic [31:0] exp_d   [2] = '{32'h30, 32'h10};
    logic [1:0]  exp_s   [2] = '{2'd2, 2'd0};
    apply_reset();
    drive(3'b010, 3'b010, 0, 32'h20, 0, 1'b1);
    tick();
    drive(3'b101, 3'b101, 32'h10, 0, 32'h30, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus.i_ready !== exp_rdy[i]) begin
        errors++; $display("FAIL wrap_ready[%0d] got=%b exp=%b", i, bus.i_ready, exp_rdy[i]);
      end
      tick();
      checks++;
      if (bus.o_data !== exp_d[i] || bus.o_src !== exp_s[i]) begin
        errors++;
        $display("FAIL wrap_out[%0d] got d=%h s=%0d exp d=%h s=%0d", i, bus.o_data, bus.o_src,
                 exp_d[i], exp_s[i]);
      end
    end
  endtask

  // Reset inside a LOCKED(2) packet, then input 0 must win immediately.
  task automatic test_reset_mid_packet;
    apply_reset();
    drive(3'b100, 3'b000, 0, 0, 32'h77, 1'b1);
    #1;
    checks++;
    if (bus.i_ready !== 3'b100) begin
      errors++; $display("FAIL rmid_lock_ready got=%b exp=100", bus.i_ready);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.i_ready !== 3'b000) begin
      errors++; $display("FAIL rmid_rst_ready got=%b exp=000", bus.i_ready);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_drop got v=%b exp v=0", bus.o_valid);
    end
    rst = 1'b0;
    drive(3'b001, 3'b001, 32'h55, 0, 0, 1'b1);
    #1;
    checks++;
    if (bus.i_ready !== 3'b001) begin
      errors++; $display("FAIL rmid_post_ready got=%b exp=001", bus.i_ready);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 32'h55 || bus.o_src !== 2'd0 ||
        bus.o_last !== 1'b1) begin
      errors++;
      $display("FAIL rmid_post_out got v=%b d=%h s=%0d l=%b exp v=1 d=00000055 s=0 l=1",
               bus.o_valid, bus.o_data, bus.o_src, bus.o_last);
    end
  endtask

  initial begin
    drive(3'b000, 3'b000, 0, 0, 0, 1'b1);
    @(negedge clk);
    test_reset();
    test_rr();
    test_packet();
    test_stall();
    test_lock_gap();
    test_wrap();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesting inputs; legal range N >= 2, need not be a power of two.
REQ-002 SHALL have parameter W, default 32: data width per input.
REQ-003 SHALL have local width L = $clog2(N) for index signals.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 i_valid  input  N  per-input request valid.
REQ-008 i_data  input  [N-1:0][W-1:0]  per-input data, packed array, index k = input k.
REQ-009 i_last  input  N  per-input end-of-packet flag.
REQ-010 i_ready  output  N  per-input accept (combinational).
REQ-011 o_valid  output  1  registered output valid.
REQ-012 o_data  output  W  registered selected data.
REQ-013 o_last  output  1  registered end-of-packet flag of o_data.
REQ-014 o_src  output  L  registered index of the input that supplied o_data.
REQ-015 o_ready  input  1  downstream accept.

Function
REQ-016 SHALL define load = !o_valid || o_ready; a transfer on input k occurs when i_valid[k] && i_ready[k].
REQ-017 SHALL hold a round-robin pointer ptr in the range 0..N-1 and a state of IDLE or LOCKED(g).
REQ-018 In IDLE, grant SHALL be the first k with i_valid[k] set, searching ptr, ptr+1, ... mod N; if no input is valid, there is no grant.
REQ-019 In LOCKED(g), grant SHALL be g regardless of the other inputs.
REQ-020 i_ready[k] SHALL be 1 only when load is set, a grant exists, and k equals the grant; at most one bit of i_ready is set per cycle.
REQ-021 On a transfer from g: o_data <= i_data[g], o_last <= i_last[g], o_src <= g, o_valid <= 1.
REQ-022 With no transfer and o_ready set, o_valid <= 0; o_data, o_last and o_src are held.
REQ-023 With o_valid set and o_ready clear, all outputs SHALL hold, and i_ready SHALL be all zeros.
REQ-024 Latency SHALL be 1 cycle from input transfer to o_valid; throughput SHALL be 1 flit per cycle under continuous o_ready.
REQ-025 Transfer with i_last[g]=0 in IDLE: next state LOCKED(g), ptr unchanged.
REQ-026 Transfer with i_last[g]=1, in any state: next state IDLE, ptr <= (g+1) mod N, with N-1 wrapping to 0 for non-power-of-two N.
REQ-027 In LOCKED(g) with i_valid[g]=0: remain locked, and SHALL NOT issue a grant to any other input.
REQ-028 Single-flit packets (i_last=1 on every flit) SHALL yield strict per-flit round-robin.
REQ-029 Upstream SHALL hold i_data and i_last stable while i_valid is set and unaccepted; the block does not check this.

Reset
REQ-030 While rst is high: o_valid=0, o_data=0, o_last=0, o_src=0, ptr=0, state IDLE, and i_ready all zeros.
REQ-031 rst asserted mid-packet SHALL drop the lock and the in-flight o_valid; the partial packet is not completed.
REQ-032 The first cycle after rst deasserts SHALL allow a grant.

Verification (N=3, W=32)
REQ-033 Reset then all i_valid=1, i_last=1, o_ready=1, data 32'hA0/A1/A2 -> i_ready one-hot 001,010,100,001; o_data A0,A1,A2,A0 each 1 cycle later; o_src 0,1,2,0.
REQ-034 Input 1 sends a 3-flit packet (11,22,33, last on 33) while input 0 is valid with 44 -> o_data 11,22,33,44 consecutively; i_ready[0]=0 during the packet.
REQ-035 o_valid=1 with o_data=A1 and o_ready=0 for 4 cycles -> o_data held at A1, i_ready=000; o_ready=1 -> stream resumes, no flit lost or duplicated.
REQ-036 After a single flit from input 1 (ptr=2), inputs 0 and 2 valid -> input 2 granted first, then input 0 (wrap).
REQ-037 rst during a LOCKED(2) packet, then input 0 valid with last=1 and data 55 -> granted on the first post-reset cycle; o_data=55, o_src=0 next cycle.
